// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store memory access unit.
// Holds the FSM encoding, default timeout, poison value and error-bit positions.
package mem_access_pkg;

   localparam int DATA_W          = 32;
   localparam int TIMEOUT_CYC_DEF = 16;

   localparam logic [DATA_W-1:0] POISON_WORD = 32'hDEADBEEF;

   localparam int ERR_MISALIGN = 0;
   localparam int ERR_TIMEOUT  = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Word address presented to the backing memory: byte offset forced to zero.
   function automatic logic [DATA_W-1:0] word_addr(input logic [DATA_W-1:0] a);
      return {a[DATA_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Backing-memory request/response bus between the access unit (master) and memory (slave).
interface mem_access_unit_if;
   import mem_access_pkg::*;

   logic              mem_req_o;
   logic              mem_we_o;
   logic [DATA_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              mem_ack_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i, mem_ack_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i, mem_ack_i
   );

endinterface

// File: rtl/mem_access_unit_wait_counter.sv
// Wait-cycle counter for outstanding memory accesses; flags the last allowed cycle.
module wait_counter #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_cnt <= '0;
      end else if (clr_i) begin
         r_cnt <= '0;
      end else if (en_i) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tc_o = (r_cnt == TERM);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: turns decoder MemRead/MemWrite into a stalled request/ack
// transaction on the backing-memory bus, with misalignment and timeout errors.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic [DATA_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              stall_o,
   output logic [1:0]        err_o,
   mem_access_unit_if.master mem
);

   state_t            r_state;
   state_t            w_next;
   logic              r_we;
   logic [DATA_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        r_err;

   logic w_one_op;
   logic w_aligned;
   logic w_start;
   logic w_misalign;
   logic w_busy;
   logic w_ack;
   logic w_tc;
   logic w_tmo;

   // Both strobes high is an illegal decode and is silently dropped.
   assign w_one_op   = MemRead_i ^ MemWrite_i;
   assign w_aligned  = (addr_i[1:0] == 2'b00);
   assign w_start    = (r_state == ST_IDLE) && w_one_op && w_aligned;
   assign w_misalign = (r_state == ST_IDLE) && w_one_op && !w_aligned;
   assign w_busy     = (r_state == ST_BUSY);
   assign w_ack      = w_busy && mem.mem_ack_i;
   assign w_tmo      = w_busy && !mem.mem_ack_i && w_tc;

   wait_counter #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wait_counter (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (!w_busy),
      .en_i  (w_busy && !mem.mem_ack_i),
      .tc_o  (w_tc)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next        = r_state;
      stall_o       = 1'b0;
      mem.mem_req_o = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               stall_o = 1'b1;
               w_next  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            stall_o       = 1'b1;
            mem.mem_req_o = 1'b1;
            if (w_ack || w_tmo) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Latched request, load result and sticky error flags.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_data  <= '0;
         r_err   <= 2'b00;
      end else begin
         if (w_start) begin
            r_we    <= MemWrite_i;
            r_addr  <= word_addr(addr_i);
            r_wdata <= data_i;
         end
         if (w_ack && !r_we) begin
            r_data <= mem.mem_rdata_i;
         end else if (w_tmo && !r_we) begin
            r_data <= POISON_WORD;
         end
         if (w_misalign) begin
            r_err[ERR_MISALIGN] <= 1'b1;
         end
         if (w_tmo) begin
            r_err[ERR_TIMEOUT] <= 1'b1;
         end
      end
   end

   assign mem.mem_we_o    = r_we;
   assign mem.mem_addr_o  = r_addr;
   assign mem.mem_wdata_o = r_wdata;
   assign data_o          = r_data;
   assign err_o           = r_err;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter TIMEOUT_CYC, default 16, SHALL be the number of BUSY cycles allowed before an access is aborted.
REQ-003 clk_i  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-low reset.
REQ-005 MemRead_i  input  1  load request from decoder.
REQ-006 MemWrite_i  input  1  store request from decoder.
REQ-007 addr_i  input  32  byte address (the ALU result).
REQ-008 data_i  input  32  store data (the rt register value).
REQ-009 data_o  output  32  load data to the write-back mux.
REQ-010 stall_o  output  1  freezes PC and register-file write while high.
REQ-011 err_o  output  2  sticky error flags: bit0 misaligned, bit1 timeout.
REQ-012 mem_req_o  output  1  backing-memory request.
REQ-013 mem_we_o  output  1  1 = write, 0 = read.
REQ-014 mem_addr_o  output  32  latched word address.
REQ-015 mem_wdata_o  output  32  latched store data.
REQ-016 mem_rdata_i  input  32  backing-memory read data, valid with ack.
REQ-017 mem_ack_i  input  1  one-cycle completion pulse from backing memory.

Function
REQ-018 The FSM SHALL have three states, IDLE, BUSY and DONE, held in a registered state variable.
REQ-019 In IDLE, a valid access SHALL assert stall_o combinationally in the same cycle, latch addr/data/we, and enter BUSY on the next edge.
  - Valid access: exactly one of MemRead_i/MemWrite_i high, and addr_i[1:0]==0.
REQ-020 If MemRead_i and MemWrite_i are both high in IDLE, the block SHALL treat the cycle as a no-op: no request, no stall, no error.
REQ-021 A misaligned access in IDLE SHALL set err_o[0], issue no request, leave stall_o low and stay in IDLE.
REQ-022 In BUSY the block SHALL drive the following from latched values until ack:
  - mem_req_o=1;
  - stall_o=1;
  - mem_we_o, mem_addr_o (with low 2 bits zeroed) and mem_wdata_o.
REQ-023 On mem_ack_i in BUSY, the block SHALL go to DONE; for a read it SHALL register mem_rdata_i into data_o.
REQ-024 In DONE the block SHALL hold stall_o=0 and mem_req_o=0, and return to IDLE on the next edge.
  - The CPU commits the instruction at the DONE edge.
REQ-025 Minimum instruction occupancy SHALL be 3 cycles (IDLE detect, BUSY with ack, DONE); each extra wait cycle SHALL add one.
REQ-026 A wait counter SHALL clear on BUSY entry and increment each BUSY cycle without ack.
REQ-027 When the counter reaches TIMEOUT_CYC-1 with no ack, the block SHALL:
  - enter DONE;
  - set err_o[1];
  - for a read, load data_o with 32'hDEADBEEF.
REQ-028 If ack and timeout occur in the same cycle, the ack SHALL win and no timeout error SHALL be flagged.
REQ-029 mem_ack_i SHALL be ignored outside BUSY.
REQ-030 data_o SHALL hold the last load value; stores and errors on writes SHALL NOT change it.
REQ-031 err_o bits SHALL be sticky until reset.

Reset
REQ-032 While rst_i=0 at an edge, the block SHALL go to IDLE and zero all of the following:
  - the wait counter;
  - data_o, err_o;
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o.
REQ-033 A reset asserted mid-BUSY SHALL drop mem_req_o at that edge; a later ack SHALL be ignored.

Structure
REQ-034 Package mem_access_pkg SHALL hold the state encoding, TIMEOUT_CYC default, the DEADBEEF poison constant and the err_o bit indices.
REQ-035 The wait counter SHALL be a sub-module named wait_counter (clear, enable, terminal-count output).

Verification
REQ-036 Read, addr 0x10, ack on first BUSY cycle with rdata 0x12345678 -> stall_o high 2 cycles, data_o=0x12345678 in DONE, err_o=0.
REQ-037 Write, addr 0x20, data 0xA5A5A5A5, ack after 4 BUSY cycles -> mem_we_o=1, mem_addr_o=0x20, mem_wdata_o=0xA5A5A5A5 held throughout, stall 5 cycles, data_o unchanged.
REQ-038 Read, addr 0x06 -> no mem_req_o, stall_o=0, err_o=2'b01.
REQ-039 Read with no ack, TIMEOUT_CYC=16 -> DONE after 16 BUSY cycles, data_o=0xDEADBEEF, err_o[1]=1.
REQ-040 rst_i low in 3rd BUSY cycle then ack one cycle later -> IDLE, mem_req_o=0, data_o=0, ack ignored.
REQ-041 MemRead_i=MemWrite_i=1 -> no request, stall_o=0, err_o unchanged.
